// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, ALU-op classes,
// datapath select encodings, FSM state encoding and the packed control word.
// The alu_op encodings are common with the ALU controller and must stay in step with it.
package multicycle_controller_pkg;

  // IR[31:26] opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  // alu_op classes
  localparam logic [1:0] ALU_MTYPE = 2'b00;  // add
  localparam logic [1:0] ALU_BTYPE = 2'b01;  // sub
  localparam logic [1:0] ALU_RTYPE = 2'b10;  // decode func field
  localparam logic [1:0] ALU_JTYPE = 2'b11;  // ALU unused

  // alu_src_b selects
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // pc_src selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_I_EXEC    = 4'd9,
    S_I_WB      = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_TRAP      = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outputs.sv
// Control-word decoder: FSM state plus mem_ready/zero -> datapath controls.
// Latency: purely combinational. Backpressure: mem_ready gates ir_write/pc_en in FETCH only.
// Ports: state, mem_ready, zero, branch_ne (invert branch condition) in; ctrl word out.
import multicycle_controller_pkg::*;

module mc_ctrl_outputs (
  input  state_t state,
  input  logic   mem_ready,
  input  logic   zero,
  input  logic   branch_ne,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_MTYPE;
        ctrl.pc_src    = PCSRC_ALU;
        // IR load and PC+4 commit together on the cycle the fetch completes
        ctrl.ir_write  = mem_ready;
        ctrl.pc_en     = mem_ready;
      end
      S_DECODE: begin
        // speculative branch target into ALUOut
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_MTYPE;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_MTYPE;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_RTYPE;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_MTYPE;
      end
      S_I_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b0;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_BTYPE;
        ctrl.pc_src    = PCSRC_ALUOUT;
        // beq takes on zero, bne on not-zero
        ctrl.pc_en     = zero ^ branch_ne;
      end
      S_JUMP: begin
        ctrl.pc_src = PCSRC_JUMP;
        ctrl.alu_op = ALU_JTYPE;
        ctrl.pc_en  = 1'b1;
      end
      S_TRAP: begin
        ctrl.illegal_op = 1'b1;
      end
      default: ctrl = '0;  // IDLE and unused encodings
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle MIPS datapath (fetch/decode/exec/mem/wb).
// Latency: Moore outputs from the state register; ir_write/FETCH pc_en gated by mem_ready, BRANCH pc_en by zero.
// Backpressure: FETCH, MEM_READ and MEM_WRITE hold their request until mem_ready; other states ignore it.
// Ports: clk, rst_n (async active-low), opcode, zero, mem_ready in; datapath controls and sticky illegal_op out.
// Build option: define MC_CTRL_BNE_EN to execute bne (opcode 000101); otherwise it traps.
import multicycle_controller_pkg::*;

module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal_op
);

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl;
  logic   branch_ne;

  // opcode is stable through BRANCH, so the branch sense is decoded live
`ifdef MC_CTRL_BNE_EN
  assign branch_ne = (opcode == OP_BNE);
`else
  assign branch_ne = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_nxt = S_R_EXEC;
          OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
          OP_ADDI:      state_nxt = S_I_EXEC;
          OP_BEQ:       state_nxt = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       state_nxt = S_BRANCH;
`endif
          OP_J:         state_nxt = S_JUMP;
          default:      state_nxt = S_TRAP;
        endcase
      end
      // only lw and sw reach MEM_ADDR
      S_MEM_ADDR:  state_nxt = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_nxt = S_MEM_WB;
      S_MEM_WB:    state_nxt = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_nxt = S_FETCH;
      S_R_EXEC:    state_nxt = S_R_WB;
      S_R_WB:      state_nxt = S_FETCH;
      S_I_EXEC:    state_nxt = S_I_WB;
      S_I_WB:      state_nxt = S_FETCH;
      S_BRANCH:    state_nxt = S_FETCH;
      S_JUMP:      state_nxt = S_FETCH;
      S_TRAP:      state_nxt = S_TRAP;  // only reset leaves the trap
      default:     state_nxt = S_IDLE;
    endcase
  end

  mc_ctrl_outputs u_outputs (
    .state     (state),
    .mem_ready (mem_ready),
    .zero      (zero),
    .branch_ne (branch_ne),
    .ctrl      (ctrl)
  );

  assign pc_en      = ctrl.pc_en;
  assign pc_src     = ctrl.pc_src;
  assign i_or_d     = ctrl.i_or_d;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign reg_write  = ctrl.reg_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign illegal_op = ctrl.illegal_op;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: an instruction-level model expands each instruction
// into its expected per-cycle control words, which are compared cycle by cycle.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write;
  logic       reg_dst, mem_to_reg, alu_src_a, illegal_op;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [15:0] dut_w;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .pc_src(pc_src), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal_op(illegal_op)
  );

  assign dut_w = {pc_en, pc_src, i_or_d, mem_read, mem_write, ir_write, reg_write,
                  reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal_op};

  typedef struct { logic rdy; logic z; logic [15:0] exp; } cyc_t;
  typedef struct { string name; logic [5:0] op; int fw; int mw; logic z; int cycles; } vec_t;

  cyc_t exp_q[$];
  vec_t tbl[8];
  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] cw(input logic pe, input logic [1:0] ps, input logic iod,
      input logic mr, input logic mw, input logic irw, input logic rw, input logic rd,
      input logic mtr, input logic sa, input logic [1:0] sb, input logic [1:0] op,
      input logic ill);
    return {pe, ps, iod, mr, mw, irw, rw, rd, mtr, sa, sb, op, ill};
  endfunction

  function automatic logic rb();
    return ($urandom & 1) != 0;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic r, input logic z, input logic [15:0] e);
    cyc_t c;
    c.rdy = r; c.z = z; c.exp = e;
    exp_q.push_back(c);
  endtask

  // Expand one instruction into its expected cycles, starting in FETCH.
  // fw/mw: wait cycles before the fetch/data access completes; tlen: cycles to hold a trap.
  task automatic build(input logic [5:0] op, input int fw, input int mw, input logic z,
                       input int tlen);
    logic trap;
    trap = 1'b0;
    for (int i = 0; i < fw; i++) push(1'b0, rb(), cw(0,2'b00,0,1,0,0,0,0,0,0,2'b01,2'b00,0));
    push(1'b1, rb(), cw(1,2'b00,0,1,0,1,0,0,0,0,2'b01,2'b00,0));
    push(rb(), rb(), cw(0,2'b00,0,0,0,0,0,0,0,0,2'b11,2'b00,0));
    case (op)
      6'b000000: begin
        push(rb(), rb(), cw(0,2'b00,0,0,0,0,0,0,0,1,2'b00,2'b10,0));
        push(rb(), rb(), cw(0,2'b00,0,0,0,0,1,1,0,0,2'b00,2'b00,0));
      end
      6'b100011: begin
        push(rb(), rb(), cw(0,2'b00,0,0,0,0,0,0,0,1,2'b10,2'b00,0));
        for (int i = 0; i < mw; i++) push(1'b0, rb(), cw(0,2'b00,1,1,0,0,0,0,0,0,2'b00,2'b00,0));
        push(1'b1, rb(), cw(0,2'b00,1,1,0,0,0,0,0,0,2'b00,2'b00,0));
        push(rb(), rb(), cw(0,2'b00,0,0,0,0,1,0,1,0,2'b00,2'b00,0));
      end
      6'b101011: begin
        push(rb(), rb(), cw(0,2'b00,0,0,0,0,0,0,0,1,2'b10,2'b00,0));
        for (int i = 0; i < mw; i++) push(1'b0, rb(), cw(0,2'b00,1,0,1,0,0,0,0,0,2'b00,2'b00,0));
        push(1'b1, rb(), cw(0,2'b00,1,0,1,0,0,0,0,0,2'b00,2'b00,0));
      end
      6'b001000: begin
        push(rb(), rb(), cw(0,2'b00,0,0,0,0,0,0,0,1,2'b10,2'b00,0));
        push(rb(), rb(), cw(0,2'b00,0,0,0,0,1,0,0,0,2'b00,2'b00,0));
      end
      6'b000100: push(rb(), z, cw(z,2'b01,0,0,0,0,0,0,0,1,2'b00,2'b01,0));
`ifdef MC_CTRL_BNE_EN
      6'b000101: push(rb(), z, cw(~z,2'b01,0,0,0,0,0,0,0,1,2'b00,2'b01,0));
`endif
      6'b000010: push(rb(), rb(), cw(1,2'b10,0,0,0,0,0,0,0,0,2'b00,2'b11,0));
      default: trap = 1'b1;
    endcase
    if (trap)
      for (int i = 0; i < tlen; i++) push(rb(), rb(), cw(0,2'b00,0,0,0,0,0,0,0,0,2'b00,2'b00,1));
  endtask

  task automatic run_n(input string name, input int n);
    cyc_t c;
    for (int k = 0; k < n; k++) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s: model ended at cycle %0d of %0d", name, k, n);
        break;
      end
      c = exp_q.pop_front();
      mem_ready = c.rdy;
      zero = c.z;
      #1;
      check($sformatf("%s[%0d]", name, k), dut_w, c.exp);
      @(negedge clk);
    end
  endtask

  // After an instruction's last cycle the controller must be fetching again.
  task automatic fetch_check(input string name);
    mem_ready = 1'b0;
    #1;
    checks++;
    if ({mem_read, mem_write, i_or_d, alu_src_a, alu_src_b, alu_op} !== 8'b1000_0100) begin
      errors++;
      $display("FAIL %s_next_fetch: got %b expected 10000100",
               name, {mem_read, mem_write, i_or_d, alu_src_a, alu_src_b, alu_op});
    end
    @(negedge clk);
  endtask

  // Entered just after a falling edge; leaves the DUT in FETCH at a falling edge.
  task automatic do_reset(input string name);
    exp_q.delete();
    #2;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    zero = 1'b1;
    #1;
    check({name, "_async"}, dut_w, 16'h0000);
    @(negedge clk);
    check({name, "_held"}, dut_w, 16'h0000);
    rst_n = 1'b1;
    #1;
    check({name, "_idle"}, dut_w, 16'h0000);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check({name, "_fetch"}, dut_w, cw(0,2'b00,0,1,0,0,0,0,0,0,2'b01,2'b00,0));
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    logic [5:0] ops[$];
    // {name, opcode, fetch waits, mem waits, zero, cycles per CPI rules}
    tbl[0] = '{"r_add",    6'b000000, 0, 0, 1'b0, 4};
    tbl[1] = '{"lw_wait3", 6'b100011, 0, 3, 1'b0, 8};
    tbl[2] = '{"lw",       6'b100011, 0, 0, 1'b1, 5};
    tbl[3] = '{"sw_w1_2",  6'b101011, 1, 2, 1'b0, 7};
    tbl[4] = '{"addi_fw2", 6'b001000, 2, 0, 1'b1, 6};
    tbl[5] = '{"beq_z1",   6'b000100, 0, 0, 1'b1, 3};
    tbl[6] = '{"beq_z0",   6'b000100, 0, 0, 1'b0, 3};
    tbl[7] = '{"j",        6'b000010, 0, 0, 1'b0, 3};

    @(negedge clk);
    check("por_all_zero", dut_w, 16'h0000);
    do_reset("reset");

    foreach (tbl[i]) begin
      opcode = tbl[i].op;
      build(tbl[i].op, tbl[i].fw, tbl[i].mw, tbl[i].z, 0);
      run_n(tbl[i].name, tbl[i].cycles);
      exp_q.delete();
      fetch_check(tbl[i].name);
    end

    // Random legal instruction stream with random memory waits and flags
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b000100, 6'b000010};
`ifdef MC_CTRL_BNE_EN
    ops.push_back(6'b000101);
`endif
    for (int n = 0; n < 150; n++) begin
      opcode = ops[$urandom_range(0, ops.size() - 1)];
      build(opcode, $urandom_range(0, 2), $urandom_range(0, 3), rb(), 0);
      run_n("rand", exp_q.size());
    end

    // Reset asserted while a load is waiting in MEM_READ
    opcode = 6'b100011;
    build(opcode, 0, 6, 1'b0, 0);
    run_n("rst_lw", 4);
    mem_ready = 1'b0;
    #1;
    check("rst_lw_in_memread", dut_w, cw(0,2'b00,1,1,0,0,0,0,0,0,2'b00,2'b00,0));
    do_reset("rst_mid_memread");

    // bne: taken on zero=0 when enabled, trap otherwise
    opcode = 6'b000101;
    build(opcode, 0, 0, 1'b0, 20);
    run_n("bne_z0", exp_q.size());
`ifdef MC_CTRL_BNE_EN
    build(opcode, 0, 0, 1'b1, 0);
    run_n("bne_z1", exp_q.size());
`endif
    do_reset("rst_after_bne");

    // Unsupported opcode traps and holds for 100 cycles
    opcode = 6'b111111;
    build(opcode, 1, 0, 1'b0, 100);
    run_n("trap", exp_q.size());
    do_reset("rst_from_trap");

    // Recovery after trap
    opcode = 6'b000000;
    build(opcode, 0, 0, 1'b0, 0);
    run_n("r_after_trap", exp_q.size());
    fetch_check("r_after_trap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
